// File: rtl/collision_scheduler.sv
// Per-frame Frogger rule sequencer: latches the frog on frame_tick, then walks one car per clock through a shared overlap comparator.
// Optional build macro GOD_MODE_EN: hits still pulse death_pulse but never cost a life or enter DEATH.
module collision_scheduler #(
   parameter int NUM_CARS    = 4,
   parameter int TILE_SIZE   = 32,
   parameter int LIVES_INIT  = 3,
   parameter int HOLD_FRAMES = 60
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_tick,
   input  logic                  start_btn,
   input  logic [9:0]            frog_x,
   input  logic [9:0]            frog_y,
   input  logic [10*NUM_CARS-1:0] car_x_bus,
   input  logic [10*NUM_CARS-1:0] car_y_bus,
   output logic [2:0]            state,
   output logic                  scan_busy,
   output logic                  death_pulse,
   output logic                  win_pulse,
   output logic                  frog_respawn,
   output logic [2:0]            lives,
   output logic [3:0]            level,
   output logic                  game_over
);

   localparam int IDX_W  = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [10:0] TILE = 11'(TILE_SIZE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_SCAN  = 3'd2,
      S_DEATH = 3'd3,
      S_WIN   = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   state_t            state_q, state_n;
   logic [IDX_W-1:0]  idx_q, idx_n;
   logic [HOLD_W-1:0] hold_q, hold_n;
   logic [2:0]        lives_q, lives_n;
   logic [3:0]        level_q, level_n;
   logic [9:0]        fx_q, fx_n, fy_q, fy_n;
   logic              death_q, death_n, win_q, win_n, resp_q, resp_n;

   logic [9:0]  car_x [NUM_CARS];
   logic [9:0]  car_y [NUM_CARS];
   logic [10:0] fx11, fy11, cx11, cy11;
   logic        hit;

   always_comb begin
      for (int i = 0; i < NUM_CARS; i++) begin
         car_x[i] = car_x_bus[10*i +: 10];
         car_y[i] = car_y_bus[10*i +: 10];
      end
   end

   // 11-bit compare so pos+TILE cannot wrap; touching edges are not a hit.
   always_comb begin
      fx11 = {1'b0, fx_q};
      fy11 = {1'b0, fy_q};
      cx11 = {1'b0, car_x[idx_q]};
      cy11 = {1'b0, car_y[idx_q]};
      hit  = (fx11 < cx11 + TILE) && (cx11 < fx11 + TILE) &&
             (fy11 < cy11 + TILE) && (cy11 < fy11 + TILE);
   end

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      hold_n  = hold_q;
      lives_n = lives_q;
      level_n = level_q;
      fx_n    = fx_q;
      fy_n    = fy_q;
      death_n = 1'b0;
      win_n   = 1'b0;
      resp_n  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_btn) begin
               state_n = S_WAIT;
               resp_n  = 1'b1;
            end
         end
         S_WAIT: begin
            if (frame_tick) begin
               state_n = S_SCAN;
               fx_n    = frog_x;
               fy_n    = frog_y;
               idx_n   = '0;
            end
         end
         S_SCAN: begin
            // Win check shares cycle 0 with car 0 and takes priority over it.
            if (idx_q == '0 && fy_q == 10'd0) begin
               state_n = S_WIN;
               win_n   = 1'b1;
               hold_n  = '0;
               level_n = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
            end else if (hit) begin
               death_n = 1'b1;
`ifdef GOD_MODE_EN
               state_n = S_WAIT;
`else
               state_n = S_DEATH;
               hold_n  = '0;
               lives_n = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
`endif
            end else if (idx_q == IDX_W'(NUM_CARS - 1)) begin
               state_n = S_WAIT;
            end else begin
               idx_n = idx_q + IDX_W'(1);
            end
         end
         S_DEATH, S_WIN: begin
            if (frame_tick) begin
               if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
                  if (state_q == S_DEATH && lives_q == 3'd0) begin
                     state_n = S_OVER;
                  end else begin
                     state_n = S_WAIT;
                     resp_n  = 1'b1;
                  end
               end else begin
                  hold_n = hold_q + HOLD_W'(1);
               end
            end
         end
         S_OVER: begin
            if (start_btn) begin
               state_n = S_WAIT;
               resp_n  = 1'b1;
               lives_n = 3'(LIVES_INIT);
               level_n = 4'd0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         lives_q <= 3'(LIVES_INIT);
         level_q <= 4'd0;
         fx_q    <= '0;
         fy_q    <= '0;
         death_q <= 1'b0;
         win_q   <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         hold_q  <= hold_n;
         lives_q <= lives_n;
         level_q <= level_n;
         fx_q    <= fx_n;
         fy_q    <= fy_n;
         death_q <= death_n;
         win_q   <= win_n;
         resp_q  <= resp_n;
      end
   end

   assign state        = state_q;
   assign scan_busy    = (state_q == S_SCAN);
   assign game_over    = (state_q == S_OVER);
   assign death_pulse  = death_q;
   assign win_pulse    = win_q;
   assign frog_respawn = resp_q;
   assign lives        = lives_q;
   assign level        = level_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Randomized bench for collision_scheduler against a frame-level game model (outcome, latency, lives, level).
module tb_collision_scheduler;

   localparam int NC   = 4;
   localparam int TILE = 32;
   localparam int LINIT = 3;
   localparam int HOLD = 60;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              frame_tick = 1'b0;
   logic              start_btn = 1'b0;
   logic [9:0]        frog_x = '0, frog_y = '0;
   logic [10*NC-1:0]  car_x_bus = '0, car_y_bus = '0;
   logic [2:0]        state;
   logic              scan_busy, death_pulse, win_pulse, frog_respawn, game_over;
   logic [2:0]        lives;
   logic [3:0]        level;

   int n_checks = 0;
   int n_fail   = 0;
   int m_lives  = LINIT;
   int m_level  = 0;
   int cx [NC];
   int cy [NC];
   logic [31:0] exp_q [$];

   collision_scheduler #(.NUM_CARS(NC), .TILE_SIZE(TILE), .LIVES_INIT(LINIT), .HOLD_FRAMES(HOLD)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
      .frog_x(frog_x), .frog_y(frog_y), .car_x_bus(car_x_bus), .car_y_bus(car_y_bus),
      .state(state), .scan_busy(scan_busy), .death_pulse(death_pulse), .win_pulse(win_pulse),
      .frog_respawn(frog_respawn), .lives(lives), .level(level), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic bit overlap(input int f, input int c);
      return (f < c + TILE) && (c < f + TILE);
   endfunction

   task automatic set_far();
      for (int i = 0; i < NC; i++) begin
         cx[i] = 900;
         cy[i] = 900;
      end
   endtask

   task automatic drive_cars();
      for (int i = 0; i < NC; i++) begin
         car_x_bus[10*i +: 10] = 10'(cx[i]);
         car_y_bus[10*i +: 10] = 10'(cy[i]);
      end
   endtask

   task automatic press_start(input string tag);
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      m_lives = LINIT;
      m_level = 0;
      check({tag, "_respawn"}, int'(frog_respawn), 1);
      check({tag, "_state"}, int'(state), 1);
      check({tag, "_lives"}, int'(lives), m_lives);
      check({tag, "_level"}, int'(level), 0);
      check({tag, "_game_over"}, int'(game_over), 0);
      step();
      check({tag, "_respawn_width"}, int'(frog_respawn), 0);
   endtask

   // One frame: model predicts outcome (0 none, 1 hit, 2 win) and its cycle latency.
   task automatic run_frame(input int fx, input int fy, input bit inject, output int kind);
      int exp_lat, exp_state, lat, dcnt, wcnt;
      kind = 0;
      exp_lat = NC;
      if (fy == 0) begin
         kind = 2;
         exp_lat = 1;
      end else begin
         for (int k = 0; k < NC; k++)
            if (kind == 0 && overlap(fx, cx[k]) && overlap(fy, cy[k])) begin
               kind = 1;
               exp_lat = k + 1;
            end
      end
      if (kind == 2) m_level = (m_level < 15) ? m_level + 1 : 15;
`ifdef GOD_MODE_EN
      exp_state = (kind == 2) ? 4 : 1;
`else
      if (kind == 1 && m_lives > 0) m_lives--;
      exp_state = (kind == 2) ? 4 : (kind == 1) ? 3 : 1;
`endif
      exp_q.push_back(32'(exp_state));
      frog_x = 10'(fx);
      frog_y = 10'(fy);
      drive_cars();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("scan_entry", int'(state), 2);
      // Frog must be latched: scramble live inputs during the scan.
      frog_x = 10'((fx + 500) % 1024);
      frog_y = 10'd0;
      lat = 0;
      dcnt = 0;
      wcnt = 0;
      for (int c = 1; c <= NC + 2; c++) begin
         if (inject && c == 1) frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         dcnt += int'(death_pulse);
         wcnt += int'(win_pulse);
         if (state != 3'd2) begin
            lat = c;
            break;
         end
      end
      check("scan_latency", lat, exp_lat);
      check("frame_state", int'(state), int'(exp_q.pop_front()));
      check("death_pulses", dcnt, (kind == 1) ? 1 : 0);
      check("win_pulses", wcnt, (kind == 2) ? 1 : 0);
      check("lives", int'(lives), m_lives);
      check("level", int'(level), m_level);
      check("scan_busy_low", int'(scan_busy), 0);
      step();
      check("pulse_cleared", int'(death_pulse) + int'(win_pulse), 0);
   endtask

   task automatic hold_phase(input int kind, output bit went_over);
      int early, hold_state;
      went_over = 1'b0;
`ifdef GOD_MODE_EN
      if (kind != 2) return;
`else
      if (kind == 0) return;
`endif
      hold_state = (kind == 2) ? 4 : 3;
      went_over = (kind == 1 && m_lives == 0);
      early = 0;
      for (int n = 1; n <= HOLD; n++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         if (n < HOLD) begin
            early += int'(frog_respawn);
            early += (int'(state) != hold_state) ? 1 : 0;
            step();
            early += int'(frog_respawn);
         end
      end
      check("hold_no_early_exit", early, 0);
      check("hold_exit_state", int'(state), went_over ? 5 : 1);
      check("hold_respawn", int'(frog_respawn), went_over ? 0 : 1);
      check("hold_game_over", int'(game_over), went_over ? 1 : 0);
      check("hold_lives", int'(lives), m_lives);
      step();
      check("hold_respawn_width", int'(frog_respawn), 0);
   endtask

   task automatic frame_and_hold(input int fx, input int fy, input bit inject);
      int kind;
      bit over;
      run_frame(fx, fy, inject, kind);
      hold_phase(kind, over);
      if (over) press_start("restart");
   endtask

   initial begin
      int rx, ry;
      // reset state
      #12;
      check("rst_state", int'(state), 0);
      check("rst_lives", int'(lives), LINIT);
      check("rst_level", int'(level), 0);
      check("rst_pulses", int'(death_pulse) + int'(win_pulse) + int'(frog_respawn), 0);
      check("rst_game_over", int'(game_over), 0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check("idle_hold", int'(state), 0);
      press_start("start");

      // car0 overlaps -> death one cycle after scan entry, respawn after HOLD ticks
      set_far();
      cx[0] = 120; cy[0] = 200;
      frame_and_hold(100, 200, 1'b0);
      // touching edge on car1 -> no hit, full scan
      set_far();
      cx[1] = 132; cy[1] = 200;
      frame_and_hold(100, 200, 1'b1);
      // row 0 with overlapping car -> win wins
      set_far();
      cx[0] = 100; cy[0] = 0;
      frame_and_hold(100, 0, 1'b0);
      // last car hit, lives down to 1
      set_far();
      cx[NC-1] = 90; cy[NC-1] = 190;
      frame_and_hold(100, 200, 1'b0);

      // reset during SCAN
      set_far();
      drive_cars();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("pre_reset_scan", int'(state), 2);
      #2 reset = 1'b1;
      #1;
      check("midscan_rst_state", int'(state), 0);
      check("midscan_rst_lives", int'(lives), LINIT);
      check("midscan_rst_level", int'(level), 0);
      check("midscan_rst_busy", int'(scan_busy), 0);
      check("midscan_rst_pulses", int'(death_pulse) + int'(win_pulse) + int'(frog_respawn), 0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check("post_rst_idle", int'(state), 0);
      press_start("start2");

      // three hits from full lives -> OVER then restart
      for (int h = 0; h < LINIT; h++) begin
         set_far();
         cx[0] = 300; cy[0] = 150;
         frame_and_hold(310, 140, 1'b0);
      end

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         rx = $urandom_range(40, 900);
         ry = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(40, 440);
         for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               cx[i] = rx + $urandom_range(0, 80) - 40;
               cy[i] = ry + $urandom_range(0, 80) - 40;
               if (cy[i] < 0) cy[i] = 0;
            end else begin
               cx[i] = $urandom_range(0, 1023);
               cy[i] = $urandom_range(0, 1023);
            end
         end
         frame_and_hold(rx, ry, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
